fifo_uart_tx: RTL and testbench
===============================

Name: fifo_uart_tx

Overview:
Consumer stage placed directly downstream of the FIFO. It drains the FIFO one byte at a time using the FIFO's CS/Insert_Delete delete handshake. Each byte is serialized as an 8N1 asynchronous frame: 1 start bit, 8 data bits LSB first, 1 stop bit. This gives the buffered data path a single-wire serial output.

Parameters:
DataWide, 8, width of each FIFO word and of the serialized payload.
ClksPerBit, 16, clk cycles per serial bit; legal range is 2 or more.

Ports:
clk  input  1  system clock, rising-edge active.
rst  input  1  asynchronous active-low reset; the block is held in reset while rst=0.
Enable  input  1  drain permission; sampled only in IDLE.
Fifo_Empty  input  1  Empty flag from the FIFO.
Fifo_Data  input  DataWide  Data_Out from the FIFO.
Fifo_CS  output  1  FIFO chip select; high for exactly one cycle per pop.
Fifo_Insert_Delete  output  1  FIFO operation select; held at 0 (Delete) at all times.
Tx  output  1  serial line; idles high.
Busy  output  1  high in every state except IDLE.
Byte_Done  output  1  one-cycle pulse on the last cycle of each stop bit.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, Tx=1, Fifo_CS=0, Fifo_Insert_Delete=0, Busy=0, Byte_Done=0.
  - Shift register, bit counter and clock counter are cleared.
- All outputs are registered or decoded directly from the registered state, so none are combinational from inputs.
- FSM states: IDLE, POP, LOAD, START, DATA, STOP.
- IDLE: if Enable=1 and Fifo_Empty=0, go to POP next cycle; otherwise stay.
- POP: lasts 1 cycle with Fifo_CS=1; the FIFO performs the delete at the rising edge ending POP. Then go to LOAD.
- LOAD: lasts 1 cycle with Fifo_CS=0. Fifo_Data is captured into the shift register at the edge ending LOAD. Then go to START.
- START: Tx=0 for ClksPerBit cycles, then go to DATA.
- DATA:
  - Tx=shift[0] for ClksPerBit cycles per bit, then shift right.
  - The bit counter runs 0..DataWide-1; after bit DataWide-1, go to STOP.
- STOP:
  - Tx=1 for ClksPerBit cycles.
  - Byte_Done=1 on the final cycle, then go to IDLE.
- Timing:
  - A frame occupies exactly (DataWide+2)*ClksPerBit cycles of Tx.
  - Back-to-back frames are spaced by 3 idle-high cycles (IDLE, POP, LOAD), so frame period = (DataWide+2)*ClksPerBit+3 cycles.
- Boundary conditions:
  - Empty FIFO: no CS pulse is issued, so the FIFO is never underflowed.
  - Fifo_Empty rising during LOAD or a later state has no effect; the popped byte is still sent.
  - Enable dropped mid-frame: the frame completes, then the block stays in IDLE.
  - Enable toggling outside IDLE is ignored.
  - Reset mid-frame: Tx returns to 1 immediately and the partial byte is discarded. No further pop occurs until reset is released and IDLE re-qualifies.
- Counter widths:
  - Clock counter is $clog2(ClksPerBit) bits and wraps at ClksPerBit-1.
  - Bit counter is $clog2(DataWide) bits.
  - No arithmetic overflow is permitted beyond these terminal counts.

Decomposition:
- Shared package (fifo_uart_pkg) holds:
  - the state encoding localparams (IDLE..STOP, 3 bits);
  - framing constants START_LEVEL=0, STOP_LEVEL=1, IDLE_LEVEL=1;
  - the default DataWide and ClksPerBit.
- One sub-module, baud_tick_gen:
  - parameterized ClksPerBit counter with a clear input;
  - outputs bit_end on the last cycle of each bit period;
  - cleared on entry to START.

Test Plan:
- Reset then idle: rst=0 for 20 ns, Fifo_Empty=1, Enable=1 -> Tx=1, Busy=0, Fifo_CS never asserted, Byte_Done=0 throughout.
- Single byte, ClksPerBit=4: FIFO model holds 0xA5, Enable=1 ->
  - exactly one Fifo_CS pulse with Fifo_Insert_Delete=0;
  - Tx sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles;
  - one Byte_Done pulse on cycle 40 of the frame.
- Back-to-back: FIFO holds 0x00,0x01,0x02 -> three frames in order; Byte_Done pulses 43 cycles apart; Tx high during the 3-cycle gaps.
- Enable control: drop Enable during bit 3 of byte 0x3C with 2 bytes queued -> 0x3C completes, no further Fifo_CS, and Busy falls after STOP.
- Reset mid-frame: assert rst=0 during DATA bit 5 -> Tx=1 and Busy=0 asynchronously. After release with Fifo_Empty=0, the next byte is popped and sent cleanly starting with a start bit.
- Integration with the FIFO (depth 16), ClksPerBit=4:
  - FIFO filled with 0x00..0x0E (15 entries) -> exactly 15 Fifo_CS pulses and 15 frames carrying 0x00..0x0E in order.
  - FIFO Empty=1 after the 15th pop; no CS pulse is issued afterwards.

Source files
------------

// File: rtl/fifo_uart_pkg.sv
// Shared state encoding, line levels and default sizing for the FIFO-fed UART transmitter.
// No logic, no latency, no flow control of its own.
package fifo_uart_pkg;

    localparam int DEF_DATA_WIDE    = 8;
    localparam int DEF_CLKS_PER_BIT = 16;

    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        POP   = 3'd1,
        LOAD  = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5
    } state_t;

endpackage

// File: rtl/fifo_uart_tx_baud.sv
// Bit-period timer: bit_end flags the last clk of every ClksPerBit-cycle bit period.
// Output decoded from the count register; clear realigns the period, no backpressure.
module baud_tick_gen #(
    parameter int ClksPerBit = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_end
);

    localparam int CW = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
    localparam logic [CW-1:0] LAST = CW'(ClksPerBit - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign bit_end = (cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops one FIFO word at a time and sends it as an 8N1 frame, LSB first, on Tx.
// Frame period (DataWide+2)*ClksPerBit+3 clks; pops only in IDLE with Enable and a non-empty FIFO.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int DataWide   = DEF_DATA_WIDE,
    parameter int ClksPerBit = DEF_CLKS_PER_BIT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                Enable,
    input  logic                Fifo_Empty,
    input  logic [DataWide-1:0] Fifo_Data,
    output logic                Fifo_CS,
    output logic                Fifo_Insert_Delete,
    output logic                Tx,
    output logic                Busy,
    output logic                Byte_Done
);

    localparam int BW = (DataWide > 1) ? $clog2(DataWide) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DataWide - 1);

    state_t              state;
    logic [DataWide-1:0] shift;
    logic [BW-1:0]       bit_cnt;
    logic                bit_end;
    logic                baud_clear;

    // Clearing during LOAD makes the first START cycle count zero.
    assign baud_clear = (state == LOAD);

    baud_tick_gen #(.ClksPerBit(ClksPerBit)) u_baud (
        .clk     (clk),
        .rst     (rst),
        .clear   (baud_clear),
        .bit_end (bit_end)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            shift   <= '0;
            bit_cnt <= '0;
        end else begin
            case (state)
                IDLE:  if (Enable && !Fifo_Empty) state <= POP;
                POP:   state <= LOAD;
                LOAD: begin
                    shift   <= Fifo_Data;
                    bit_cnt <= '0;
                    state   <= START;
                end
                START: if (bit_end) state <= DATA;
                DATA: begin
                    if (bit_end) begin
                        shift <= shift >> 1;
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            state   <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                STOP:  if (bit_end) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        Tx = IDLE_LEVEL;
        case (state)
            START:   Tx = START_LEVEL;
            DATA:    Tx = shift[0];
            STOP:    Tx = STOP_LEVEL;
            default: Tx = IDLE_LEVEL;
        endcase
    end

    assign Fifo_CS            = (state == POP);
    assign Fifo_Insert_Delete = 1'b0;
    assign Busy               = (state != IDLE);
    assign Byte_Done          = (state == STOP) && bit_end;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FIFO model feeding the DUT, frame-timeline reference model, line decoder.
module tb_fifo_uart_tx;

    localparam int C      = 4;
    localparam int DW     = 8;
    localparam int FRAME  = (DW + 2) * C;
    localparam int PERIOD = FRAME + 3;
    localparam int MAXC   = 20000;

    logic          clk        = 1'b0;
    logic          rst        = 1'b1;
    logic          Enable     = 1'b0;
    logic          Fifo_Empty = 1'b1;
    logic [DW-1:0] Fifo_Data  = '0;
    logic          Fifo_CS, Fifo_Insert_Delete, Tx, Busy, Byte_Done;

    fifo_uart_tx #(.DataWide(DW), .ClksPerBit(C)) dut (
        .clk                (clk),
        .rst                (rst),
        .Enable             (Enable),
        .Fifo_Empty         (Fifo_Empty),
        .Fifo_Data          (Fifo_Data),
        .Fifo_CS            (Fifo_CS),
        .Fifo_Insert_Delete (Fifo_Insert_Delete),
        .Tx                 (Tx),
        .Busy               (Busy),
        .Byte_Done          (Byte_Done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [7:0] fq[$];
    logic [7:0] expq[$];
    int         underflow = 0;
    bit         pop_req;

    int cyc = 0;
    int cs_cyc[$];
    int done_cyc[$];
    bit tx_log[MAXC];

    int         frame_t = -1;
    logic [7:0] cur = '0;
    int         k, idx;
    bit         e_tx, e_busy, e_cs, e_done;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Show-ahead-free FIFO: a delete registers the head word onto Data_Out.
    always @(posedge clk) begin
        pop_req = Fifo_CS && !Fifo_Insert_Delete;
        #1;
        if (pop_req) begin
            if (fq.size() == 0) underflow++;
            else Fifo_Data = fq.pop_front();
        end
        Fifo_Empty = (fq.size() == 0);
    end

    // Reference: a frame is a fixed timeline anchored at the pop cycle.
    always @(negedge clk) begin
        if (cyc < MAXC) tx_log[cyc] = Tx;
        if (Fifo_CS)   cs_cyc.push_back(cyc);
        if (Byte_Done) done_cyc.push_back(cyc);
        e_tx = 1'b1; e_busy = 1'b0; e_cs = 1'b0; e_done = 1'b0;
        if (!rst) begin
            frame_t = -1;
        end else begin
            if (frame_t >= 0 && cyc - frame_t > FRAME + 1) frame_t = -1;
            if (frame_t >= 0) begin
                k      = cyc - frame_t;
                e_busy = 1'b1;
                e_cs   = (k == 0);
                e_done = (k == FRAME + 1);
                if (k >= 2) begin
                    idx = (k - 2) / C;
                    if (idx == 0)      e_tx = 1'b0;
                    else if (idx <= DW) e_tx = cur[idx-1];
                    else               e_tx = 1'b1;
                end
            end else if (Enable && !Fifo_Empty) begin
                frame_t = cyc + 1;
                cur     = (expq.size() > 0) ? expq.pop_front() : 8'h00;
            end
        end
        chk("tx",         int'(Tx),                 int'(e_tx));
        chk("busy",       int'(Busy),               int'(e_busy));
        chk("fifo_cs",    int'(Fifo_CS),            int'(e_cs));
        chk("byte_done",  int'(Byte_Done),          int'(e_done));
        chk("insert_del", int'(Fifo_Insert_Delete), 0);
        cyc++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [7:0] b);
        fq.push_back(b);
        expq.push_back(b);
    endtask

    task automatic wait_cs(input int target, input int budget);
        int i = 0;
        while (cs_cyc.size() < target && i < budget) begin tick(1); i++; end
        chk("cs_wait_timeout", int'(cs_cyc.size() >= target), 1);
    endtask

    task automatic wait_done(input int target, input int budget);
        int i = 0;
        while (done_cyc.size() < target && i < budget) begin tick(1); i++; end
        chk("done_wait_timeout", int'(done_cyc.size() >= target), 1);
    endtask

    function automatic int cs_at(input int i);
        return (i < cs_cyc.size()) ? cs_cyc[i] : -1000;
    endfunction

    // Receiver: samples mid-bit from the logged line, -1 on bad framing.
    function automatic int decode(input int cs);
        int s = cs + 2;
        int v = 0;
        if (s < 0 || s + FRAME >= MAXC) return -1;
        if (tx_log[s + C/2] != 1'b0 || tx_log[s + (DW+1)*C + C/2] != 1'b1) return -1;
        for (int b = 0; b < DW; b++) v |= int'(tx_log[s + (b+1)*C + C/2]) << b;
        return v;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin
        int         cs0, d0, c0, np;
        logic [9:0] lit;
        logic [7:0] rnd[$];

        // Reset with an empty FIFO and Enable high.
        rst = 1'b0;
        Enable = 1'b1;
        #20;
        chk("rst_tx",   int'(Tx),   1);
        chk("rst_busy", int'(Busy), 0);
        @(posedge clk); #2;
        rst = 1'b1;
        tick(20);
        chk("idle_cs_count",   cs_cyc.size(),   0);
        chk("idle_done_count", done_cyc.size(), 0);

        // Single byte 0xA5.
        Enable = 1'b0;
        push(8'hA5);
        tick(2);
        cs0 = cs_cyc.size(); d0 = done_cyc.size();
        Enable = 1'b1;
        wait_done(d0 + 1, 100);
        chk("a5_cs_count", cs_cyc.size() - cs0, 1);
        c0  = cs_at(cs0);
        lit = 10'b1101001010;
        for (int i = 0; i < 10; i++)
            for (int j = 0; j < C; j++)
                chk("a5_line_bit", (c0 >= 0) ? int'(tx_log[c0 + 2 + i*C + j]) : -1, int'(lit[i]));
        chk("a5_done_offset", (done_cyc.size() > d0) ? done_cyc[d0] - c0 : -1, 41);

        // Back-to-back 0x00, 0x01, 0x02.
        Enable = 1'b0;
        push(8'h00); push(8'h01); push(8'h02);
        tick(2);
        cs0 = cs_cyc.size(); d0 = done_cyc.size();
        Enable = 1'b1;
        wait_done(d0 + 3, 3*PERIOD + 50);
        for (int i = 0; i < 3; i++) chk("b2b_byte", decode(cs_at(cs0 + i)), i);
        for (int i = 0; i < 2; i++) begin
            chk("b2b_spacing", (done_cyc.size() > d0 + i + 1) ? done_cyc[d0+i+1] - done_cyc[d0+i] : -1, 43);
            for (int j = 1; j <= 3; j++)
                chk("b2b_gap_high", (done_cyc.size() > d0 + i) ? int'(tx_log[done_cyc[d0+i] + j]) : -1, 1);
        end

        // Enable dropped during bit 3 of 0x3C with two more bytes queued.
        Enable = 1'b0;
        push(8'h3C); push(8'h11); push(8'h22);
        tick(2);
        cs0 = cs_cyc.size(); d0 = done_cyc.size();
        Enable = 1'b1;
        wait_cs(cs0 + 1, 20);
        tick(18);
        Enable = 1'b0;
        wait_done(d0 + 1, 60);
        chk("en_busy_after_stop", int'(Busy), 0);
        tick(30);
        chk("en_no_more_cs", cs_cyc.size() - cs0, 1);
        chk("en_byte", decode(cs_at(cs0)), 8'h3C);

        // Reset during data bit 5 of 0x11, then 0x22 goes out cleanly.
        cs0 = cs_cyc.size();
        Enable = 1'b1;
        wait_cs(cs0 + 1, 20);
        tick(26);
        rst = 1'b0;
        #1;
        chk("midrst_tx",   int'(Tx),   1);
        chk("midrst_busy", int'(Busy), 0);
        tick(3);
        rst = 1'b1;
        cs0 = cs_cyc.size(); d0 = done_cyc.size();
        wait_done(d0 + 1, 100);
        chk("postrst_cs_count", cs_cyc.size() - cs0, 1);
        chk("postrst_byte", decode(cs_at(cs0)), 8'h22);

        // Random traffic with Enable toggling at arbitrary times.
        cs0 = cs_cyc.size(); d0 = done_cyc.size(); np = 0;
        for (int c = 0; c < 600; c++) begin
            Enable = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 19) == 0 && fq.size() < 16) begin
                rnd.push_back(8'($urandom_range(0, 255)));
                push(rnd[np]);
                np++;
            end
            tick(1);
        end
        Enable = 1'b1;
        wait_done(d0 + np, np*PERIOD + 100);
        for (int i = 0; i < np; i++) chk("rand_byte", decode(cs_at(cs0 + i)), int'(rnd[i]));

        // Integration: 15 queued words drain in order, then no further pops.
        Enable = 1'b0;
        for (int i = 0; i < 15; i++) push(8'(i));
        tick(2);
        cs0 = cs_cyc.size(); d0 = done_cyc.size();
        Enable = 1'b1;
        wait_done(d0 + 15, 15*PERIOD + 100);
        tick(60);
        chk("int_cs_count",   cs_cyc.size() - cs0,   15);
        chk("int_done_count", done_cyc.size() - d0, 15);
        for (int i = 0; i < 15; i++) chk("int_byte", decode(cs_at(cs0 + i)), i);
        chk("int_fifo_empty", int'(Fifo_Empty), 1);
        chk("underflow", underflow, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
